accum_frame_ctrl: RTL

Frame sequencer for the parallel lane accumulator datapath. Accepts PAR_FACTOR-wide input beats over a valid/ready handshake and drives the datapath enable and lane data. After a programmed number of beats, flushes the datapath pipeline, captures the saturated sum and overflow status into a result register, and presents them over a valid/ready handshake. It then clears the datapath for the next frame. Sits between the upstream sample stream and the accumulator datapath.

---
 rtl/accum_frame_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/accum_frame_ctrl.sv
// rtl/accum_frame_ctrl.sv - frame sequencer for the parallel lane accumulator datapath
// Define ACC_CTRL_TIMEOUT_EN to close stalled frames after TIMEOUT_CYCLES idle cycles.
module accum_frame_ctrl #(
    parameter int PAR_FACTOR     = 4,
    parameter int DATA_WIDTH     = 4,
    parameter int ACC_WIDTH      = 8,
    parameter int CNT_WIDTH      = 8,
    parameter int DRAIN_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [CNT_WIDTH-1:0]             frame_len,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH*PAR_FACTOR-1:0] in_data,
    output logic [DATA_WIDTH*PAR_FACTOR-1:0] lane_data,
    output logic                             acc_en,
    output logic                             acc_clr,
    input  logic [ACC_WIDTH-1:0]             acc_data,
    input  logic                             acc_ovf,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [ACC_WIDTH-1:0]             res_data,
    output logic                             res_ovf,
    output logic [CNT_WIDTH-1:0]             res_beats,
    output logic                             res_timeout,
    output logic                             busy
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ACCUM = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_CLEAR = 3'd4;
    localparam int DRW = $clog2(DRAIN_CYCLES + 1);

    logic [2:0]           state;
    logic [CNT_WIDTH-1:0] len_q;
    logic [CNT_WIDTH-1:0] beat_cnt;
    logic [DRW-1:0]       drain_cnt;
    logic                 ovf_sticky;
    logic                 accept;
    logic                 last_beat;
    logic                 drain_last;
    logic                 idle_expire;
    logic                 timed_out;

    assign in_ready   = (state == S_ACCUM);
    assign accept     = in_ready && in_valid;
    assign acc_en     = accept || (state == S_DRAIN);
    assign lane_data  = accept ? in_data : '0;
    assign last_beat  = accept && ((beat_cnt + 1'b1) == len_q);
    assign drain_last = (state == S_DRAIN) && (drain_cnt == DRW'(DRAIN_CYCLES - 1));
    assign res_valid  = (state == S_DONE);
    assign acc_clr    = (state == S_CLEAR);
    assign busy       = (state != S_IDLE);

`ifdef ACC_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;

    assign idle_expire = in_ready && !accept && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt  <= '0;
            timed_out <= 1'b0;
        end else begin
            if (!in_ready || accept)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;
            // flag survives DRAIN so the capture can report it
            if (state == S_IDLE)
                timed_out <= 1'b0;
            else if (idle_expire && beat_cnt != '0)
                timed_out <= 1'b1;
        end
    end
`else
    assign idle_expire = 1'b0;
    assign timed_out   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            len_q       <= '0;
            beat_cnt    <= '0;
            drain_cnt   <= '0;
            ovf_sticky  <= 1'b0;
            res_data    <= '0;
            res_ovf     <= 1'b0;
            res_beats   <= '0;
            res_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && frame_len != '0) begin
                        len_q      <= frame_len;
                        beat_cnt   <= '0;
                        ovf_sticky <= 1'b0;
                        state      <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    ovf_sticky <= ovf_sticky | acc_ovf;
                    drain_cnt  <= '0;
                    if (accept)
                        beat_cnt <= beat_cnt + 1'b1;
                    if (last_beat)
                        state <= S_DRAIN;
                    else if (idle_expire)
                        state <= (beat_cnt != '0) ? S_DRAIN : S_IDLE;
                end
                S_DRAIN: begin
                    ovf_sticky <= ovf_sticky | acc_ovf;
                    drain_cnt  <= drain_cnt + 1'b1;
                    if (drain_last) begin
                        res_data    <= acc_data;
                        res_ovf     <= ovf_sticky | acc_ovf;
                        res_beats   <= beat_cnt;
                        res_timeout <= timed_out;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (res_ready)
                        state <= S_CLEAR;
                end
                S_CLEAR: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
